// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment driver: a shift-history of recent results plus direct
// per-digit writes, scanned one digit per prescaler slot with blanking, blink and polarity control.
module seg7_scan_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int BLINK_DIV      = 25000000,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  result_valid,
  input  logic [3:0]            result_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [3:0]            wr_data,
  input  logic                  clear,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  hex_mode,
  input  logic                  blink_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            result_count
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // XOR-ing an active-high value with the "off" level applies the output polarity.
  localparam logic [6:0]            SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = ACTIVE_LOW_SEG;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW_AN ? '1 : '0;

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } entry_t;

  entry_t                  r_store [NUM_DIGITS];
  entry_t                  w_store_nxt [NUM_DIGITS];
  logic [7:0]              r_count;
  logic [NUM_DIGITS-1:0]   r_dp_in;
  logic [PRE_W-1:0]        r_prescaler;
  logic [IDX_W-1:0]        r_scan_idx;
  logic [BLK_W-1:0]        r_blink_cnt;
  logic                    r_blink_phase;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_wr_in_range;
  logic                    w_wr_hit;
  logic                    w_pre_tc;
  entry_t                  w_cur;
  logic                    w_shown;
  logic [6:0]              w_seg_hi;
  logic                    w_dp_hi;
  logic                    w_blink_off;
  logic                    w_an_on;
  logic [NUM_DIGITS-1:0]   w_an_hi;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h00;
    case (v)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_wr_in_range = (32'(wr_idx) < 32'(NUM_DIGITS));
  // A push owns entry 0; a write to any other index lands on top of the shifted store.
  assign w_wr_hit      = wr_en && w_wr_in_range && !(result_valid && (wr_idx == '0));

  // NOTE: every variable written in a combinational block gets a full default first,
  // otherwise the untouched paths infer latches.
  always_comb begin
    w_store_nxt = r_store;
    if (result_valid) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) w_store_nxt[i] = r_store[i-1];
      w_store_nxt[0] = '{valid: 1'b1, value: result_data};
    end
    if (w_wr_hit) w_store_nxt[wr_idx] = '{valid: 1'b1, value: wr_data};
    if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) w_store_nxt[i] = '{valid: 1'b0, value: r_store[i].value};
    end
  end

  // NOTE: the digit store is reset along with the control state: its valid bits decide
  // what is lit, so it cannot be left to power-up contents like a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_store[i] <= '0;
      r_count <= '0;
      r_dp_in <= '0;
    end else begin
      r_store <= w_store_nxt;
      r_dp_in <= dp_in;
      if (result_valid && (r_count != 8'hFF)) r_count <= r_count + 8'd1;
    end
  end

  assign w_pre_tc = (r_prescaler == PRE_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescaler   <= '0;
      r_scan_idx    <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_prescaler <= w_pre_tc ? '0 : r_prescaler + 1'b1;
      if (w_pre_tc) r_scan_idx <= (r_scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
      if (!blink_en) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= 1'b0;
      end else if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // A valid entry that decodes to blank (decimal mode, value >= 10) is treated like an empty one.
  always_comb begin
    w_cur       = r_store[r_scan_idx];
    w_shown     = w_cur.valid && (hex_mode || (w_cur.value < 4'd10));
    w_seg_hi    = w_shown ? seg_decode(w_cur.value) : 7'h00;
    w_dp_hi     = r_dp_in[r_scan_idx];
    w_blink_off = (r_scan_idx == '0) && blink_en && r_blink_phase;
    w_an_on     = (32'(r_prescaler) >= 32'(BLANK_CYCLES)) && (w_shown || w_dp_hi) && !w_blink_off;
    w_an_hi     = w_an_on ? (NUM_DIGITS'(1) << r_scan_idx) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= w_seg_hi ^ SEG_OFF;
      r_dp  <= w_dp_hi ^ DP_OFF;
      r_an  <= w_an_hi ^ AN_OFF;
    end
  end

  assign seg          = r_seg;
  assign dp           = r_dp;
  assign an           = r_an;
  assign result_count = r_count;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: 4 digits, 4-cycle slots, 1 blank cycle,
// blink half-period 8, active-low outputs. Outputs are sampled on the falling edge.
module tb_seg7_scan_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       result_valid = 1'b0;
  logic [3:0] result_data = '0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = '0;
  logic [3:0] wr_data = '0;
  logic       clear = 1'b0;
  logic [3:0] dp_in = '0;
  logic       hex_mode = 1'b1;
  logic       blink_en = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic [7:0] result_count;

  int n_checks = 0;
  int n_pass   = 0;

  int         on_cnt [4];
  logic [6:0] seg_of [4];
  logic       dp_of  [4];
  int         multi_cnt, seg_lit_cnt, dp_lit_cnt;

  seg7_scan_display #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLINK_DIV(8),
    .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .result_valid(result_valid), .result_data(result_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .clear(clear), .dp_in(dp_in), .hex_mode(hex_mode), .blink_en(blink_en),
    .seg(seg), .dp(dp), .an(an), .result_count(result_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Observe a window of output cycles and gather per-digit statistics.
  task automatic scan(input int cycles);
    for (int d = 0; d < 4; d++) begin
      on_cnt[d] = 0;
      seg_of[d] = 7'h55;
      dp_of[d]  = 1'b1;
    end
    multi_cnt = 0; seg_lit_cnt = 0; dp_lit_cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if ($countones(~an) > 1) multi_cnt++;
      if (seg !== 7'h7F) seg_lit_cnt++;
      if (dp !== 1'b1) dp_lit_cnt++;
      for (int d = 0; d < 4; d++) begin
        if (an[d] === 1'b0) begin
          on_cnt[d]++;
          seg_of[d] = seg;
          dp_of[d]  = dp;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] v);
    result_valid = 1'b1; result_data = v;
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  task automatic write(input logic [1:0] idx, input logic [3:0] v);
    wr_en = 1'b1; wr_idx = idx; wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_an(input int d, input logic want_low, input string tag);
    int n;
    n = 0;
    while (((an[d] === 1'b0) != want_low) && (n < 64)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 64), 32'd1);
  endtask

  initial begin
    // 1: reset state and idle
    idle(2);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_count", 32'(result_count), 32'd0);
    rst_n = 1'b1;
    scan(32);
    check("idle_an_on", 32'(on_cnt[0] + on_cnt[1] + on_cnt[2] + on_cnt[3]), 32'd0);
    check("idle_seg_lit", 32'(seg_lit_cnt), 32'd0);
    check("idle_dp_lit", 32'(dp_lit_cnt), 32'd0);
    check("idle_count", 32'(result_count), 32'd0);

    // 2: push 3,7,1 -> entries 1,7,3,invalid
    push(4'd3); push(4'd7); push(4'd1);
    idle(2);
    scan(16);
    check("p3_d0_seg", 32'(seg_of[0]), 32'(7'b1111001));
    check("p3_d1_seg", 32'(seg_of[1]), 32'(7'b1111000));
    check("p3_d2_seg", 32'(seg_of[2]), 32'(7'b0110000));
    check("p3_d0_on", 32'(on_cnt[0]), 32'd3);
    check("p3_d1_on", 32'(on_cnt[1]), 32'd3);
    check("p3_d2_on", 32'(on_cnt[2]), 32'd3);
    check("p3_d3_off", 32'(on_cnt[3]), 32'd0);
    check("p3_single_an", 32'(multi_cnt), 32'd0);
    check("p3_count", 32'(result_count), 32'd3);

    // 3: five pushes 0..4 -> 4,3,2,1; then saturation
    for (int v = 0; v < 5; v++) push(4'(v));
    idle(2);
    scan(16);
    check("p5_d0_seg", 32'(seg_of[0]), 32'(7'b0011001));
    check("p5_d3_seg", 32'(seg_of[3]), 32'(7'b1111001));
    check("p5_d3_on", 32'(on_cnt[3]), 32'd3);
    check("p5_count", 32'(result_count), 32'd8);
    result_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      result_data = 4'(i);
      @(negedge clk);
    end
    result_valid = 1'b0;
    check("sat_count", 32'(result_count), 32'd255);

    // 4: direct writes, push/write priority, hex mode
    do_reset();
    check("r2_count", 32'(result_count), 32'd0);
    push(4'd5); push(4'd6); push(4'd7); push(4'd8);
    result_valid = 1'b1; result_data = 4'd9;
    wr_en = 1'b1; wr_idx = 2'd2; wr_data = 4'hA;
    @(negedge clk);
    result_valid = 1'b0; wr_en = 1'b0;
    idle(2);
    scan(16);
    check("pw_d0_seg", 32'(seg_of[0]), 32'(7'b0010000));
    check("pw_d1_seg", 32'(seg_of[1]), 32'(7'b0000000));
    check("pw_d2_seg", 32'(seg_of[2]), 32'(7'b0001000));
    check("pw_d3_seg", 32'(seg_of[3]), 32'(7'b0000010));
    check("pw_d2_on", 32'(on_cnt[2]), 32'd3);
    check("pw_count", 32'(result_count), 32'd5);
    hex_mode = 1'b0;
    idle(1);
    scan(16);
    check("dec_d2_off", 32'(on_cnt[2]), 32'd0);
    check("dec_d0_on", 32'(on_cnt[0]), 32'd3);
    hex_mode = 1'b1;
    write(2'd3, 4'hC);
    result_valid = 1'b1; result_data = 4'd1;
    wr_en = 1'b1; wr_idx = 2'd0; wr_data = 4'd2;
    @(negedge clk);
    result_valid = 1'b0; wr_en = 1'b0;
    idle(2);
    scan(16);
    check("pw0_d0_seg", 32'(seg_of[0]), 32'(7'b1111001));
    check("pw0_d3_seg", 32'(seg_of[3]), 32'(7'b0001000));
    check("pw0_count", 32'(result_count), 32'd6);

    // 5: clear with push, then decimal point on an empty digit
    clear = 1'b1; result_valid = 1'b1; result_data = 4'd3;
    @(negedge clk);
    clear = 1'b0; result_valid = 1'b0;
    idle(2);
    scan(16);
    check("clr_an_on", 32'(on_cnt[0] + on_cnt[1] + on_cnt[2] + on_cnt[3]), 32'd0);
    check("clr_count", 32'(result_count), 32'd7);
    dp_in = 4'b0100;
    idle(2);
    scan(16);
    check("dp_d2_on", 32'(on_cnt[2]), 32'd3);
    check("dp_others_off", 32'(on_cnt[0] + on_cnt[1] + on_cnt[3]), 32'd0);
    check("dp_d2_seg", 32'(seg_of[2]), 32'h7F);
    check("dp_d2_dp", 32'(dp_of[2]), 32'd0);
    dp_in = 4'b0000;
    idle(2);

    // 6: blink aligned so digit 0's lit cycles fall in the dark half-period
    push(4'd2); push(4'd5);
    idle(2);
    wait_an(1, 1'b0, "sync_d1_high");
    wait_an(1, 1'b1, "sync_d1_low");
    idle(3);
    blink_en = 1'b1;
    scan(64);
    check("blink_d0_dark", 32'(on_cnt[0]), 32'd0);
    check("blink_d1_on", 32'(on_cnt[1]), 32'd12);
    blink_en = 1'b0;
    scan(16);
    check("steady_d0_on", 32'(on_cnt[0]), 32'd3);

    // asynchronous reset while digit 0 is lit
    wait_an(0, 1'b1, "sync_d0_low");
    check("pre_rst_an", 32'(an), 32'hE);
    #1 rst_n = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'hF);
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_dp", 32'(dp), 32'd1);
    check("arst_count", 32'(result_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
